// File: rtl/rs_preio_soc_link.sv
// SoC-side serial endpoint on the forwarded fabric clock: byte serializer onto SOC_IN,
// framed-byte deserializer from SOC_OUT. One bit per clock, no oversampling.
module rs_preio_soc_link #(
  parameter bit PARITY_EN = 1'b1
) (
  input  logic       SOC_CLK,
  input  logic       SOC_RST_N,
  input  logic [7:0] TX_DATA,
  input  logic       TX_VALID,
  output logic       TX_READY,
  output logic       SOC_IN,
  input  logic       SOC_OUT,
  output logic [7:0] RX_DATA,
  output logic       RX_VALID,
  output logic       RX_PERR,
  output logic       RX_FERR
);

  typedef enum logic [2:0] {TXS_IDLE, TXS_START, TXS_DATA, TXS_PAR, TXS_STOP} tx_st_e;
  typedef enum logic [2:0] {RXS_IDLE, RXS_DATA, RXS_PAR, RXS_STOP, RXS_BREAK} rx_st_e;

  tx_st_e     tx_st, tx_st_n;
  logic [7:0] tx_sh, tx_sh_n;
  logic [2:0] tx_cnt, tx_cnt_n;
  logic       tx_par, tx_par_n;
  logic       soc_in_n, tx_ready_n, tx_accept;

  rx_st_e     rx_st, rx_st_n;
  logic       rx_q;
  logic [7:0] rx_sh, rx_sh_n;
  logic [2:0] rx_cnt, rx_cnt_n;
  logic       rx_pbad, rx_pbad_n;
  logic [7:0] rx_data_n;
  logic       rx_valid_n, rx_perr_n, rx_ferr_n;

  // SOC_IN/TX_READY are registered, so they are decoded from the next state.
  always_comb begin
    tx_accept = TX_VALID && TX_READY;
    tx_st_n   = tx_st;
    tx_sh_n   = tx_sh;
    tx_cnt_n  = tx_cnt;
    tx_par_n  = tx_par;
    case (tx_st)
      TXS_IDLE, TXS_STOP: begin
        if (tx_accept) begin
          tx_st_n  = TXS_START;
          tx_sh_n  = TX_DATA;
          tx_par_n = ^TX_DATA;
        end else if (tx_st == TXS_STOP) begin
          tx_st_n = TXS_IDLE;
        end
      end
      TXS_START: begin
        tx_st_n  = TXS_DATA;
        tx_cnt_n = 3'd0;
      end
      TXS_DATA: begin
        tx_sh_n  = {1'b0, tx_sh[7:1]};
        tx_cnt_n = tx_cnt + 3'd1;
        if (tx_cnt == 3'd7) tx_st_n = PARITY_EN ? TXS_PAR : TXS_STOP;
      end
      TXS_PAR: tx_st_n = TXS_STOP;
      default: tx_st_n = TXS_IDLE;
    endcase
    case (tx_st_n)
      TXS_START: soc_in_n = 1'b0;
      TXS_DATA:  soc_in_n = tx_sh_n[0];
      TXS_PAR:   soc_in_n = tx_par_n;
      default:   soc_in_n = 1'b1;
    endcase
    tx_ready_n = (tx_st_n == TXS_IDLE) || (tx_st_n == TXS_STOP);
  end

  always_comb begin
    rx_st_n    = rx_st;
    rx_sh_n    = rx_sh;
    rx_cnt_n   = rx_cnt;
    rx_pbad_n  = rx_pbad;
    rx_valid_n = 1'b0;
    rx_data_n  = RX_DATA;
    rx_perr_n  = RX_PERR;
    rx_ferr_n  = RX_FERR;
    case (rx_st)
      RXS_IDLE: begin
        if (!rx_q) begin
          rx_st_n  = RXS_DATA;
          rx_cnt_n = 3'd0;
        end
      end
      RXS_DATA: begin
        rx_sh_n  = {rx_q, rx_sh[7:1]};
        rx_cnt_n = rx_cnt + 3'd1;
        if (rx_cnt == 3'd7) rx_st_n = PARITY_EN ? RXS_PAR : RXS_STOP;
      end
      RXS_PAR: begin
        rx_pbad_n = rx_q ^ (^rx_sh);
        rx_st_n   = RXS_STOP;
      end
      RXS_STOP: begin
        rx_valid_n = 1'b1;
        rx_data_n  = rx_sh;
        rx_perr_n  = PARITY_EN && rx_pbad;
        rx_ferr_n  = !rx_q;
        rx_st_n    = rx_q ? RXS_IDLE : RXS_BREAK;
      end
      // a line held low after a bad stop must not look like a new start bit
      RXS_BREAK: if (rx_q) rx_st_n = RXS_IDLE;
      default:   rx_st_n = RXS_IDLE;
    endcase
  end

  always_ff @(posedge SOC_CLK) begin
    if (!SOC_RST_N) begin
      tx_st    <= TXS_IDLE;
      tx_sh    <= 8'h00;
      tx_cnt   <= 3'd0;
      tx_par   <= 1'b0;
      SOC_IN   <= 1'b1;
      TX_READY <= 1'b1;
      rx_st    <= RXS_IDLE;
      rx_q     <= 1'b1;
      rx_sh    <= 8'h00;
      rx_cnt   <= 3'd0;
      rx_pbad  <= 1'b0;
      RX_VALID <= 1'b0;
      RX_DATA  <= 8'h00;
      RX_PERR  <= 1'b0;
      RX_FERR  <= 1'b0;
    end else begin
      tx_st    <= tx_st_n;
      tx_sh    <= tx_sh_n;
      tx_cnt   <= tx_cnt_n;
      tx_par   <= tx_par_n;
      SOC_IN   <= soc_in_n;
      TX_READY <= tx_ready_n;
      rx_st    <= rx_st_n;
      rx_q     <= SOC_OUT;
      rx_sh    <= rx_sh_n;
      rx_cnt   <= rx_cnt_n;
      rx_pbad  <= rx_pbad_n;
      RX_VALID <= rx_valid_n;
      RX_DATA  <= rx_data_n;
      RX_PERR  <= rx_perr_n;
      RX_FERR  <= rx_ferr_n;
    end
  end

endmodule

// File: tb/tb_rs_preio_soc_link.sv
// Bench for rs_preio_soc_link: parity instance driven directly, no-parity instance looped back.
module tb_rs_preio_soc_link;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready, soc_in, soc_out;
  logic [7:0] rx_data;
  logic       rx_valid, rx_perr, rx_ferr;

  logic [7:0] np_tx_data;
  logic       np_tx_valid, np_tx_ready, np_line;
  logic [7:0] np_rx_data;
  logic       np_rx_valid, np_rx_perr, np_rx_ferr;

  rs_preio_soc_link #(.PARITY_EN(1'b1)) dut_p (
    .SOC_CLK(clk), .SOC_RST_N(rst_n), .TX_DATA(tx_data), .TX_VALID(tx_valid),
    .TX_READY(tx_ready), .SOC_IN(soc_in), .SOC_OUT(soc_out), .RX_DATA(rx_data),
    .RX_VALID(rx_valid), .RX_PERR(rx_perr), .RX_FERR(rx_ferr));

  rs_preio_soc_link #(.PARITY_EN(1'b0)) dut_np (
    .SOC_CLK(clk), .SOC_RST_N(rst_n), .TX_DATA(np_tx_data), .TX_VALID(np_tx_valid),
    .TX_READY(np_tx_ready), .SOC_IN(np_line), .SOC_OUT(np_line), .RX_DATA(np_rx_data),
    .RX_VALID(np_rx_valid), .RX_PERR(np_rx_perr), .RX_FERR(np_rx_ferr));

  typedef struct {
    logic [7:0] d;
    logic       p;
    logic       f;
    int         at;
  } rx_exp_t;

  rx_exp_t rx_sb[$];
  logic    tx_sb[$];
  logic    bits[$];
  int      checks = 0;
  int      errors = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_tx_frame(input logic [7:0] d);
    tx_sb.push_back(1'b0);
    for (int i = 0; i < 8; i++) tx_sb.push_back(d[i]);
    tx_sb.push_back(^d);
    tx_sb.push_back(1'b1);
  endtask

  task automatic push_idle(input int n);
    repeat (n) bits.push_back(1'b1);
  endtask

  task automatic build_frame(input logic [7:0] d, input logic pflip, input logic stop, input int hold_low);
    rx_exp_t e;
    e.d = d; e.p = pflip; e.f = !stop; e.at = bits.size() + 12;
    rx_sb.push_back(e);
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    bits.push_back((^d) ^ pflip);
    bits.push_back(stop);
    repeat (hold_low) bits.push_back(1'b0);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; soc_out = 1'b1;
    np_tx_valid = 1'b0; np_tx_data = 8'h00;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if ({soc_in, tx_ready, rx_valid, rx_data, rx_perr, rx_ferr} !== {1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got in=%b rdy=%b vld=%b data=%h perr=%b ferr=%b, want 1 1 0 00 0 0",
               soc_in, tx_ready, rx_valid, rx_data, rx_perr, rx_ferr);
    end
    checks++;
    if ({np_line, np_tx_ready, np_rx_valid} !== 3'b110) begin
      errors++;
      $display("FAIL reset_state_np: got line=%b rdy=%b vld=%b, want 1 1 0", np_line, np_tx_ready, np_rx_valid);
    end
  endtask

  task automatic test_tx_single;
    logic b;
    tx_sb.delete();
    push_tx_frame(8'hA5);
    tx_data = 8'hA5; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    for (int i = 0; i < 11; i++) begin
      if (i == 3) tx_data = 8'hFF;
      b = tx_sb.pop_front();
      checks++;
      if (soc_in !== b) begin
        errors++;
        $display("FAIL tx_single_bit%0d: got %b want %b", i, soc_in, b);
      end
      checks++;
      if (tx_ready !== (i == 10)) begin
        errors++;
        $display("FAIL tx_single_ready%0d: got %b want %b", i, tx_ready, (i == 10));
      end
      tick();
    end
    checks++;
    if ({soc_in, tx_ready} !== 2'b11) begin
      errors++;
      $display("FAIL tx_single_idle: got in=%b rdy=%b want 1 1", soc_in, tx_ready);
    end
  endtask

  task automatic test_tx_back_to_back;
    logic b;
    tx_sb.delete();
    push_tx_frame(8'h01);
    push_tx_frame(8'hFF);
    tx_data = 8'h01; tx_valid = 1'b1;
    tick();
    tx_data = 8'hFF;
    for (int i = 0; i < 22; i++) begin
      b = tx_sb.pop_front();
      checks++;
      if (soc_in !== b) begin
        errors++;
        $display("FAIL tx_b2b_bit%0d: got %b want %b", i, soc_in, b);
      end
      checks++;
      if (tx_ready !== (i == 10 || i == 21)) begin
        errors++;
        $display("FAIL tx_b2b_ready%0d: got %b want %b", i, tx_ready, (i == 10 || i == 21));
      end
      tick();
      if (i == 10) tx_valid = 1'b0;
    end
  endtask

  task automatic test_rx;
    rx_exp_t    e;
    logic [7:0] last_d;
    bits.delete(); rx_sb.delete();
    push_idle(2);
    build_frame(8'h3C, 1'b0, 1'b1, 0);
    build_frame(8'h81, 1'b0, 1'b1, 0);
    push_idle(3);
    build_frame(8'h3C, 1'b1, 1'b1, 0);
    push_idle(2);
    build_frame(8'h3C, 1'b0, 1'b0, 4);
    push_idle(4);
    build_frame(8'h5A, 1'b0, 1'b1, 0);
    push_idle(2);
    last_d = 8'h00;
    for (int i = 0; i < bits.size() + 16; i++) begin
      soc_out = (i < bits.size()) ? bits[i] : 1'b1;
      if (rx_valid) begin
        checks++;
        if (rx_sb.size() == 0) begin
          errors++;
          $display("FAIL rx_unexpected_valid: got valid at cycle %0d, want none", i);
        end else begin
          e = rx_sb.pop_front();
          if (rx_data !== e.d || rx_perr !== e.p || rx_ferr !== e.f || i != e.at) begin
            errors++;
            $display("FAIL rx_frame: got data=%h perr=%b ferr=%b at %0d, want data=%h perr=%b ferr=%b at %0d",
                     rx_data, rx_perr, rx_ferr, i, e.d, e.p, e.f, e.at);
          end
          last_d = e.d;
        end
      end else begin
        checks++;
        if (rx_data !== last_d) begin
          errors++;
          $display("FAIL rx_data_hold: got %h at cycle %0d, want %h", rx_data, i, last_d);
        end
      end
      tick();
    end
    checks++;
    if (rx_sb.size() != 0) begin
      errors++;
      $display("FAIL rx_missing: got %0d frames outstanding, want 0", rx_sb.size());
    end
  endtask

  task automatic test_reset_mid;
    tx_data = 8'hC3; tx_valid = 1'b1; soc_out = 1'b1;
    tick();
    tx_valid = 1'b0; soc_out = 1'b0;
    tick();
    soc_out = 1'b1;
    tick();
    soc_out = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    checks++;
    if ({soc_in, tx_ready, rx_valid, rx_data, rx_perr, rx_ferr} !== {1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid: got in=%b rdy=%b vld=%b data=%h perr=%b ferr=%b, want 1 1 0 00 0 0",
               soc_in, tx_ready, rx_valid, rx_data, rx_perr, rx_ferr);
    end
    rst_n = 1'b1; soc_out = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (rx_valid !== 1'b0 || soc_in !== 1'b1 || tx_ready !== 1'b1) begin
        errors++;
        $display("FAIL reset_release%0d: got vld=%b in=%b rdy=%b, want 0 1 1", i, rx_valid, soc_in, tx_ready);
      end
    end
  endtask

  task automatic test_loopback;
    rx_exp_t e;
    int      sent, last_at;
    logic    adv;
    rx_sb.delete();
    sent = 0; last_at = -1;
    np_tx_data = 8'h00; np_tx_valid = 1'b1;
    for (int cyc = 0; cyc < 3000 && (sent < 256 || rx_sb.size() != 0); cyc++) begin
      adv = 1'b0;
      if (np_tx_valid && np_tx_ready) begin
        e.d = np_tx_data; e.p = 1'b0; e.f = 1'b0; e.at = -1;
        rx_sb.push_back(e);
        adv = 1'b1;
      end
      if (np_rx_valid) begin
        checks++;
        if (rx_sb.size() == 0) begin
          errors++;
          $display("FAIL loop_unexpected: got valid data=%h, want none", np_rx_data);
        end else begin
          e = rx_sb.pop_front();
          if (np_rx_data !== e.d || np_rx_perr !== 1'b0 || np_rx_ferr !== 1'b0) begin
            errors++;
            $display("FAIL loop_byte: got data=%h perr=%b ferr=%b, want %h 0 0",
                     np_rx_data, np_rx_perr, np_rx_ferr, e.d);
          end
        end
        if (last_at >= 0) begin
          checks++;
          if (cyc - last_at != 10) begin
            errors++;
            $display("FAIL loop_period: got %0d cycles, want 10", cyc - last_at);
          end
        end
        last_at = cyc;
      end
      tick();
      if (adv) begin
        sent++;
        if (sent == 256) np_tx_valid = 1'b0;
        else np_tx_data = np_tx_data + 8'd1;
      end
    end
    checks++;
    if (sent != 256 || rx_sb.size() != 0) begin
      errors++;
      $display("FAIL loop_timeout: got sent=%0d outstanding=%0d, want 256 0", sent, rx_sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_tx_single();
    test_tx_back_to_back();
    test_rx();
    test_reset_mid();
    test_loopback();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
